// File: rtl/numpad_emulator.sv
// 4x4 keypad model: turns valid/ready key-press commands into active-low row
// responses to the scanner's column strobes. Define NUMPAD_EMULATOR_BOUNCE_EN to model contact bounce.
module numpad_emulator #(
    parameter int HOLD_SCANS     = 8,
    parameter int GAP_SCANS      = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] columns,
    output logic [3:0] rows,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       done,
    output logic       timeout
);

    localparam int CMAX = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef NUMPAD_EMULATOR_BOUNCE_EN
        BOUNCE,
`endif
        PRESS,
        GAP,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [3:0]    sync1, cs, cs_d;
    logic [1:0]    col, col_n, row, row_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          closed, closed_n;
    logic          timeout_q, timeout_n;
    logic [3:0]    rows_n;
    logic          accept, act, cs_ok, active, tmo_hit;
`ifdef NUMPAD_EMULATOR_BOUNCE_EN
    logic [1:0]    bcnt, bcnt_n;
`endif

    assign accept    = key_valid && (state == IDLE);
    assign act       = cs_d[col] && !cs[col];
    assign cnt_inc   = (cnt == CW'(CMAX)) ? cnt : cnt + 1'b1;
    assign key_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign timeout   = timeout_q;

    always_comb begin
        case (cs)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: cs_ok = 1'b1;
            default:                            cs_ok = 1'b0;
        endcase
    end

    always_comb begin
        active = (state == PRESS) || (state == GAP);
`ifdef NUMPAD_EMULATOR_BOUNCE_EN
        if (state == BOUNCE) active = 1'b1;
`endif
    end

    // Any activation counts as column activity, so it wins over an expiring timer.
    assign tmo_hit = active && !act && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tcnt_n    = tcnt;
        closed_n  = closed;
        timeout_n = 1'b0;
        col_n     = col;
        row_n     = row;
`ifdef NUMPAD_EMULATOR_BOUNCE_EN
        bcnt_n    = bcnt;
`endif
        if (active) begin
            if (act)
                tcnt_n = '0;
            else if (tcnt != TW'(TIMEOUT_CYCLES - 1))
                tcnt_n = tcnt + 1'b1;
        end
        case (state)
            IDLE: begin
                if (accept) begin
                    col_n  = key_code[3:2];
                    row_n  = key_code[1:0];
                    cnt_n  = '0;
                    tcnt_n = '0;
`ifdef NUMPAD_EMULATOR_BOUNCE_EN
                    state_n  = BOUNCE;
                    bcnt_n   = '0;
                    closed_n = 1'b0;
`else
                    state_n  = PRESS;
                    closed_n = 1'b1;
`endif
                end
            end
`ifdef NUMPAD_EMULATOR_BOUNCE_EN
            // Contact alternates closed/open/closed; the 4th activation is PRESS activation 1.
            BOUNCE: begin
                if (act) begin
                    if (bcnt == 2'd3) begin
                        state_n  = PRESS;
                        cnt_n    = CW'(1);
                        closed_n = 1'b1;
                    end else begin
                        bcnt_n   = bcnt + 1'b1;
                        closed_n = ~bcnt[0];
                    end
                end
            end
`endif
            PRESS: begin
                if (act) begin
                    if (cnt_inc >= CW'(HOLD_SCANS)) begin
                        state_n = GAP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n   = cnt_inc;
                    end
                end
            end
            // The contact stays closed until the first GAP activation so the
            // final hold activation keeps its whole column window.
            GAP: begin
                if (act) begin
                    closed_n = 1'b0;
                    if (cnt_inc >= CW'(GAP_SCANS)) begin
                        state_n = DONE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n   = cnt_inc;
                    end
                end
            end
            DONE: begin
                state_n  = IDLE;
                closed_n = 1'b0;
                tcnt_n   = '0;
            end
            default: begin
                state_n  = IDLE;
                closed_n = 1'b0;
            end
        endcase
        if (tmo_hit) begin
            state_n   = IDLE;
            closed_n  = 1'b0;
            timeout_n = 1'b1;
            cnt_n     = '0;
            tcnt_n    = '0;
        end
    end

    always_comb begin
        rows_n = 4'b1111;
        if (closed_n && cs_ok && !cs[col_n])
            rows_n = ~(4'b0001 << row_n);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sync1     <= 4'b1111;
            cs        <= 4'b1111;
            cs_d      <= 4'b1111;
            col       <= '0;
            row       <= '0;
            cnt       <= '0;
            tcnt      <= '0;
            closed    <= 1'b0;
            timeout_q <= 1'b0;
            rows      <= 4'b1111;
`ifdef NUMPAD_EMULATOR_BOUNCE_EN
            bcnt      <= '0;
`endif
        end else begin
            state     <= state_n;
            sync1     <= columns;
            cs        <= sync1;
            cs_d      <= cs;
            col       <= col_n;
            row       <= row_n;
            cnt       <= cnt_n;
            tcnt      <= tcnt_n;
            closed    <= closed_n;
            timeout_q <= timeout_n;
            rows      <= rows_n;
`ifdef NUMPAD_EMULATOR_BOUNCE_EN
            bcnt      <= bcnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_numpad_emulator.sv
// Directed bench for numpad_emulator: full press on a rotating scan, invalid
// columns, async reset mid-press, key 15 decode and the no-activity timeout.
module tb_numpad_emulator;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] columns = 4'b1111;
    logic [3:0] rows;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_ready, busy, done, timeout;

    int errors = 0;
    int checks = 0;
    int done_total = 0;
    int tmo_total = 0;

`ifdef NUMPAD_EMULATOR_BOUNCE_EN
    localparam int PRE = 3;
`else
    localparam int PRE = 0;
`endif
    localparam int NW = PRE + 16;

    numpad_emulator dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .columns   (columns),
        .rows      (rows),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    always #10 clock = ~clock;

    always @(posedge clock) begin
        if (done)    done_total <= done_total + 1;
        if (timeout) tmo_total  <= tmo_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press_cmd(input logic [3:0] k);
        @(negedge clock);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
    endtask

    // Contact state of the key during the n-th key-column window (0-based).
    function automatic bit pressed(input int n);
        if (n < PRE) return (n != 1);
        return (n < PRE + 8);
    endfunction

    initial begin
        logic [3:0] one;
        logic [3:0] exp;
        int win, done_seen, n, done_before, tmo_before;
        bit pend, stuck;
        one = 4'b0001;

        // reset state
        #15;
        chk("rst_rows", rows, 4'b1111);
        chk("rst_ready", key_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // key 9 (column 2, row 1) on a rotating scan, 64 clocks per column
        columns = 4'b1110;
        press_cmd(4'd9);
        win = 0; done_seen = 0; pend = 0;
        for (int r = 0; r < NW + 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                columns = ~(one << c);
                for (int t = 0; t < 64; t++) begin
                    @(negedge clock);
                    if (done) begin
                        done_seen++;
                        pend = 1;
                    end else if (pend) begin
                        chk("ready_after_done", key_ready, 1'b1);
                        pend = 0;
                    end
                    if (t == 32) begin
                        if (c == 2)
                            exp = (win < NW && pressed(win)) ? 4'b1101 : 4'b1111;
                        else
                            exp = 4'b1111;
                        chk($sformatf("scan_rows_r%0d_c%0d", r, c), rows, exp);
                    end
                end
                if (c == 2) win++;
            end
        end
        chk("done_once", done_seen, 1);
        chk("idle_after_scan", key_ready, 1'b1);

        // key 0 with an invalid column pattern mid-press, then reset at activation 4
        columns = 4'b1111;
        tick(4);
        press_cmd(4'd0);
        key_code  = 4'd15;
        key_valid = 1'b1;                          // ignored while busy
        columns = 4'b1110; tick(8);
        key_valid = 1'b0;
        chk("k0_act1", rows, pressed(0) ? 4'b1110 : 4'b1111);
        columns = 4'b0011; tick(8);
        chk("k0_invalid_cols", rows, 4'b1111);
        columns = 4'b1110; tick(8);
        chk("k0_act2", rows, pressed(1) ? 4'b1110 : 4'b1111);
        columns = 4'b1111; tick(8);
        chk("k0_no_col", rows, 4'b1111);
        columns = 4'b1110; tick(8);
        columns = 4'b1111; tick(8);
        columns = 4'b1110; tick(8);
        chk("k0_act4", rows, 4'b1110);
        done_before = done_total;
        tmo_before  = tmo_total;
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_rows", rows, 4'b1111);
        chk("async_rst_ready", key_ready, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(10);
        chk("no_done_after_rst", done_total, done_before);
        chk("no_tmo_after_rst", tmo_total, tmo_before);

        // key 15: row 3 driven only on column 3
        columns = 4'b1111;
        press_cmd(4'd15);
        columns = 4'b0111; tick(8);
        chk("k15_rows", rows, 4'b0111);
        columns = 4'b1110; tick(8);
        chk("k15_other_col", rows, 4'b1111);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        columns = 4'b1111;
        tick(4);

        // key 5 with no column activity: timeout 65536 clocks after accept
        press_cmd(4'd5);
        n = 0; stuck = 0;
        while (n < 70000) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (rows !== 4'b1111) stuck = 1;
            if (timeout) break;
        end
        chk("timeout_clock", n, 65536);
        chk("timeout_rows_idle", stuck, 1'b0);
        chk("timeout_ready", key_ready, 1'b1);
        tick(1);
        chk("timeout_one_cycle", timeout, 1'b0);
        chk("timeout_no_done", done_total, done_before);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/numpad_emulator.md
Name: numpad_emulator

Overview:
- Synthesizable 4x4 keypad model; the key-matrix end of the numpad scan interface.
- Watches the scanner's active-low column strobes and drives active-low row lines, as a physical key closure would.
- Takes key-press commands over a valid/ready handshake, e.g. from a UART command block or a self-test sequencer.
- Lets the calculator be exercised without a physical keypad.

Parameters:
- HOLD_SCANS, 8: number of activations of the key's column during which the key reads as pressed.
- GAP_SCANS, 8: number of activations of the key's column with the key released before done is issued.
- TIMEOUT_CYCLES, 65536: clocks without any activation of the key's column before the press is aborted.

Ports:
- clock  input  1  system clock, 50 MHz
- reset_n  input  1  asynchronous, active-low reset
- columns  input  4  column strobes from scanner, active-low, one-hot-low when valid
- rows  output  4  row lines to scanner, active-low, 4'b1111 = no key
- key_valid  input  1  press request
- key_code  input  4  key to press: column = key_code[3:2], row = key_code[1:0] (code = column*4 + row)
- key_ready  output  1  high in IDLE only
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse: press/release sequence completed
- timeout  output  1  one-cycle pulse: sequence aborted, no column activity

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous, active-low. Reset can be asserted at any time.
- Reset values:
  - rows = 4'b1111, key_ready = 1, busy = 0, done = 0, timeout = 0.
  - FSM in IDLE; all counters 0; synchronizer flops = 4'b1111.
- Column synchronizer: columns pass through a 2-flop synchronizer to give cs.
- Activation: a cycle in which cs[c] goes 1 to 0, where c = the latched column. This is detected with one more registered copy of cs.
- Column validity: if cs is not exactly one-hot-low, rows = 4'b1111 that cycle, in every state.
- Row drive: rows is registered.
  - When PRESS is active and cs[c] = 0 and cs is valid, rows = ~(4'b0001 << r). r is the latched row.
  - Otherwise rows = 4'b1111.
  - Response latency from a columns change to rows is 3 clocks. This is well inside the scanner's 256-clock settle window.
- Handshake: the command is accepted on a cycle with key_valid & key_ready. key_code is latched on that edge.
- FSM states and transitions:
  - IDLE: key_ready = 1. On accept, go to PRESS and clear the activation count and timeout count.
  - PRESS: count activations. At the activation that makes the count reach HOLD_SCANS, go to GAP and clear the count. rows is driven during that final activation's column window.
  - GAP: rows = 4'b1111. At the activation that makes the count reach GAP_SCANS, go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- Timeout:
  - In PRESS or GAP, the timeout counter increments every clock and clears on each activation.
  - When it reaches TIMEOUT_CYCLES-1: pulse timeout for one cycle, force rows = 4'b1111, go to IDLE. done is not pulsed.
- Reset mid-press: rows releases asynchronously to 4'b1111. No done or timeout pulse is issued.
- key_valid outside IDLE is ignored; no queuing.
- Counter widths: $clog2(max parameter + 1) bits. Counters saturate and never wrap.

Optional Feature:
- Macro: NUMPAD_EMULATOR_BOUNCE_EN.
- When defined, an extra state BOUNCE sits between accept and PRESS. It models contact bounce:
  - Activation 1: key pressed.
  - Activation 2: key released.
  - Activation 3: key pressed.
  - The 4th activation enters PRESS, and that activation counts as PRESS activation 1.
- BOUNCE activations do not count toward HOLD_SCANS. The timeout rules of PRESS apply in BOUNCE.
- When not defined: no BOUNCE state; accept goes straight to PRESS. This is the default.

Test Plan:
- Press key 9 with HOLD_SCANS=8 and GAP_SCANS=8, scanner model rotating columns every 512 clocks. Required response:
  - rows = 4'b1101 only while columns = 4'b1011, and rows = 4'b1111 at all other times.
  - This holds for exactly 8 activations of column 2, then rows stays high for 8 activations.
  - done pulses once; key_ready rises the cycle after done.
- Connect to the numpad scanner and press key_code 0, then 15. Required response: the scanner's value output shows 5'h10 and 5'h1F once each.
- Hold columns = 4'b1111 after accepting key 5. Required response: rows stays 4'b1111, timeout pulses at clock 65536 after accept, then IDLE.
- Drive columns = 4'b0011 during PRESS of key 0. Required response: rows = 4'b1111 for those cycles.
- Assert reset_n low at the 4th activation of PRESS. Required response:
  - rows = 4'b1111 immediately, without waiting for a clock edge.
  - key_ready = 1, and no done pulse.
- With NUMPAD_EMULATOR_BOUNCE_EN defined, press key 4. Required response:
  - Over column-1 activations, rows reads 1110, 1111, 1110, then 1110 for 8 activations.
  - Then rows stays 1111 for 8 activations, then done pulses.
